data_mem_lsu: RTL and testbench

Byte-addressed, parametrised successor to the word-only data memory, sitting between the execute stage and the RAM array of the RV32I core. It executes RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and sign/zero-extended reads. It detects misaligned, illegal-size and out-of-range accesses, and presents a req/ready/valid handshake with configurable wait states.

---
 rtl/data_mem_lsu.sv | 197 +++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressed RV32I load/store unit in front of a word RAM.
// Executes LB/LH/LW/LBU/LHU and SB/SH/SW with byte-lane writes and
// sign/zero-extended reads. Misaligned, illegal-size and out-of-range accesses
// are rejected with err_o. A req/ready/valid handshake is used, and
// WAIT_STATES extra cycles can be inserted between accept and response.
//
// Ports:
//   clk_i     clock (rising edge)
//   rst_i     synchronous active-high reset
//   req_i     request strobe, accepted when req_i && ready_o
//   ready_o   block can accept a request this cycle
//   we_i      1 = store, 0 = load
//   funct3_i  RV32I access size/sign code
//   addr_i    byte address
//   data_i    store data, right-aligned
//   data_o    load result (0 for stores and errors), held until next response
//   valid_o   one-cycle response pulse per accepted request
//   err_o     qualifies valid_o: the access was rejected
module data_mem_lsu #(
    parameter  int MEM_SIZE    = 1024,
    parameter  int ADDR_WIDTH  = $clog2(MEM_SIZE) + 2,
    parameter  int WAIT_STATES = 0,
    localparam int DATA_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  ready_o,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  err_o
);

    localparam int IDX_W = $clog2(MEM_SIZE);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       accept;

    // Captured request
    logic                  r_we;
    logic [2:0]            r_f3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    // Request actually being committed this edge
    logic                  c_we;
    logic [2:0]            c_f3;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic                  commit;

    logic                  illegal, misal, oor, c_err;
    logic [IDX_W-1:0]      c_idx;
    logic [1:0]            c_lane;
    logic [3:0]            wmask;
    logic [DATA_WIDTH-1:0] wdata, rdword, ld_val;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    assign ready_o = !rst_i && (state != S_WAIT);
    assign accept  = req_i && ready_o;
    assign valid_o = (state == S_RESP);

    // With no wait states the commit edge is the accept edge itself, so the
    // live inputs are used; otherwise the captured copy is used.
    assign c_we   = (WAIT_STATES == 0) ? we_i     : r_we;
    assign c_f3   = (WAIT_STATES == 0) ? funct3_i : r_f3;
    assign c_addr = (WAIT_STATES == 0) ? addr_i   : r_addr;
    assign c_data = (WAIT_STATES == 0) ? data_i   : r_data;
    assign commit = (WAIT_STATES == 0) ? accept
                                       : (state == S_WAIT && cnt == 4'd0 && !rst_i);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_nxt = S_RESP;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture; contents are don't-care until the next accept.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            r_we   <= we_i;
            r_f3   <= funct3_i;
            r_addr <= addr_i;
            r_data <= data_i;
        end
    end

    // ---------------- Decode / checks ----------------
    always_comb begin
        case (c_f3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = c_we;   // no unsigned stores
            default:                illegal = 1'b1;
        endcase
    end

    assign misal  = ((c_f3[1:0] == 2'b01) && c_addr[0]) ||
                    ((c_f3[1:0] == 2'b10) && (c_addr[1:0] != 2'b00));
    assign oor    = ({1'b0, c_addr} >= ADDR_LIMIT);
    assign c_err  = illegal || misal || oor;
    assign c_idx  = c_addr[IDX_W+1:2];
    assign c_lane = c_addr[1:0];

    // Store lanes: data is replicated so each lane picks its own byte.
    always_comb begin
        wmask = 4'b0000;
        wdata = c_data;
        case (c_f3[1:0])
            2'b00: begin
                wmask = 4'b0001 << c_lane;
                wdata = {4{c_data[7:0]}};
            end
            2'b01: begin
                wmask = c_lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{c_data[15:0]}};
            end
            2'b10:   wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (commit && c_we && !c_err) begin
            for (int k = 0; k < 4; k++) begin
                if (wmask[k]) mem[c_idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Load extraction
    assign rdword   = mem[c_idx];
    assign byte_sel = rdword[8*c_lane +: 8];
    assign half_sel = c_lane[1] ? rdword[31:16] : rdword[15:0];

    always_comb begin
        case (c_f3)
            3'b000:  ld_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  ld_val = rdword;
            3'b100:  ld_val = {24'd0, byte_sel};
            3'b101:  ld_val = {16'd0, half_sel};
            default: ld_val = '0;
        endcase
    end

    // Response registers, held between responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o <= '0;
            err_o  <= 1'b0;
        end else if (commit) begin
            err_o  <= c_err;
            data_o <= (c_err || c_we) ? '0 : ld_val;
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

    localparam int MS = 1024;
    localparam int AW = 14;   // wide enough to express out-of-range addresses

    logic          clk = 0;
    logic          rst_a, rst_b, req_a, req_b;
    logic          we_s;
    logic [2:0]    f3_s;
    logic [AW-1:0] addr_s;
    logic [31:0]   data_s;
    logic          ready_a, valid_a, err_a, ready_b, valid_b, err_b;
    logic [31:0]   data_a, data_b;

    always #5 clk = ~clk;

    data_mem_lsu #(.MEM_SIZE(MS), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .ready_o(ready_a), .we_i(we_s),
        .funct3_i(f3_s), .addr_i(addr_s), .data_i(data_s), .data_o(data_a),
        .valid_o(valid_a), .err_o(err_a));

    data_mem_lsu #(.MEM_SIZE(MS), .ADDR_WIDTH(AW), .WAIT_STATES(3)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .ready_o(ready_b), .we_i(we_s),
        .funct3_i(f3_s), .addr_i(addr_s), .data_i(data_s), .data_o(data_b),
        .valid_o(valid_b), .err_o(err_b));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- Reference model (byte-addressed) ----------------
    logic [7:0] mm [int];

    task automatic model(input logic we, input logic [2:0] f3, input int addr,
                         input logic [31:0] d, output logic err, output logic [31:0] res);
        int sz;
        bit sgn;
        logic [31:0] v;
        err = 0; res = 0; sz = 1; sgn = 0;
        case (f3)
            3'd0: begin sz = 1; sgn = 1; end
            3'd1: begin sz = 2; sgn = 1; end
            3'd2: sz = 4;
            3'd4: begin sz = 1; err = we; end
            3'd5: begin sz = 2; err = we; end
            default: err = 1;
        endcase
        if (addr % sz != 0) err = 1;
        if (addr >= 4 * MS) err = 1;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < sz; i++) mm[addr + i] = d[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < sz; i++) v = v | (32'(mm[addr + i]) << (8 * i));
                if (sgn && v[8*sz-1] && sz < 4) v = v | (32'hFFFF_FFFF << (8 * sz));
                res = v;
            end
        end
    endtask

    // ---------------- Response scoreboard for dut_a ----------------
    typedef struct { int due; logic err; logic [31:0] data; } exp_t;
    exp_t q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (valid_a) begin
            if (q.size() == 0) chk("unexpected_valid_a", 32'd1, 32'd0);
            else begin
                mon_e = q.pop_front();
                chk("resp_cycle_a", cyc, mon_e.due);
                chk("err_a", {31'd0, err_a}, {31'd0, mon_e.err});
                chk("data_a", data_a, mon_e.data);
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            chk("missing_valid_a", 32'd0, 32'd1);
            void'(q.pop_front());
        end
    end

    // Present one request to dut_a for one cycle; called #1 after a posedge.
    task automatic issue_a(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic ee, input logic [31:0] ed);
        exp_t e;
        we_s = we; f3_s = f3; addr_s = a; data_s = d; req_a = 1;
        e.due = cyc + 1; e.err = ee; e.data = ed;
        q.push_back(e);
        @(posedge clk); #1;
        req_a = 0;
    endtask

    task automatic issue_a_model(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                                 input logic [31:0] d);
        logic ee;
        logic [31:0] ed;
        model(we, f3, int'(a), d, ee, ed);
        issue_a(we, f3, a, d, ee, ed);
    endtask

    // One request to dut_b (3 wait states) with its full timing checked.
    task automatic issue_b_timed(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                                 input logic [31:0] d, input logic ee, input logic [31:0] ed);
        we_s = we; f3_s = f3; addr_s = a; data_s = d; req_b = 1;
        @(posedge clk); #1;
        req_b = 0;
        repeat (3) begin
            @(negedge clk);
            chk("b_ready_in_wait", {31'd0, ready_b}, 32'd0);
            chk("b_valid_in_wait", {31'd0, valid_b}, 32'd0);
        end
        @(negedge clk);
        chk("b_valid_resp", {31'd0, valid_b}, 32'd1);
        chk("b_ready_resp", {31'd0, ready_b}, 32'd1);
        chk("b_err", {31'd0, err_b}, {31'd0, ee});
        chk("b_data", data_b, ed);
        @(negedge clk);
        chk("b_valid_pulse_end", {31'd0, valid_b}, 32'd0);
        chk("b_data_held", data_b, ed);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic we; logic [2:0] f3; logic [AW-1:0] addr; logic [31:0] data;
        logic err; logic [31:0] dout;
    } vec_t;
    vec_t vecs [24];

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 14'h0000, 32'h01020304, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 3'b010, 14'h0010, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 3'b010, 14'h0010, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 3'b000, 14'h0011, 32'h00000080, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 3'b000, 14'h0011, 32'h0,        1'b0, 32'hFFFFFF80};
        vecs[5]  = '{1'b0, 3'b100, 14'h0011, 32'h0,        1'b0, 32'h00000080};
        vecs[6]  = '{1'b0, 3'b010, 14'h0010, 32'h0,        1'b0, 32'hDEAD80EF};
        vecs[7]  = '{1'b1, 3'b010, 14'h0014, 32'h89ABCDEF, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 3'b001, 14'h0016, 32'hFFFF1234, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 3'b101, 14'h0016, 32'h0,        1'b0, 32'h00001234};
        vecs[10] = '{1'b0, 3'b001, 14'h0014, 32'h0,        1'b0, 32'hFFFFCDEF};
        vecs[11] = '{1'b0, 3'b010, 14'h0014, 32'h0,        1'b0, 32'h1234CDEF};
        vecs[12] = '{1'b0, 3'b010, 14'h0002, 32'h0,        1'b1, 32'h0};
        vecs[13] = '{1'b0, 3'b001, 14'h0001, 32'h0,        1'b1, 32'h0};
        vecs[14] = '{1'b0, 3'b011, 14'h0010, 32'h0,        1'b1, 32'h0};
        vecs[15] = '{1'b1, 3'b010, 14'h1000, 32'hCAFEF00D, 1'b1, 32'h0};
        vecs[16] = '{1'b1, 3'b100, 14'h0010, 32'h55555555, 1'b1, 32'h0};
        vecs[17] = '{1'b1, 3'b001, 14'h0013, 32'h00007777, 1'b1, 32'h0};
        vecs[18] = '{1'b0, 3'b010, 14'h0010, 32'h0,        1'b0, 32'hDEAD80EF};
        vecs[19] = '{1'b0, 3'b010, 14'h0000, 32'h0,        1'b0, 32'h01020304};
        vecs[20] = '{1'b0, 3'b101, 14'h0012, 32'h0,        1'b0, 32'h0000DEAD};
        vecs[21] = '{1'b1, 3'b010, 14'h0FFC, 32'h55AA33CC, 1'b0, 32'h0};
        vecs[22] = '{1'b0, 3'b000, 14'h0FFF, 32'h0,        1'b0, 32'h00000055};
        vecs[23] = '{1'b0, 3'b010, 14'h0FFC, 32'h0,        1'b0, 32'h55AA33CC};

        rst_a = 1; rst_b = 1; req_a = 0; req_b = 0;
        we_s = 0; f3_s = 0; addr_s = 0; data_s = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_a_in_reset", {31'd0, ready_a}, 32'd0);
        chk("ready_b_in_reset", {31'd0, ready_b}, 32'd0);
        @(posedge clk); #1;
        rst_a = 0; rst_b = 0;
        @(negedge clk);
        chk("ready_a_after_reset", {31'd0, ready_a}, 32'd1);
        chk("valid_a_after_reset", {31'd0, valid_a}, 32'd0);
        chk("err_a_after_reset", {31'd0, err_a}, 32'd0);
        chk("data_a_after_reset", data_a, 32'd0);
        chk("ready_b_after_reset", {31'd0, ready_b}, 32'd1);
        chk("data_b_after_reset", data_b, 32'd0);
        @(posedge clk); #1;

        // Directed vectors, issued back-to-back on the zero-wait instance.
        foreach (vecs[i]) begin
            logic ee;
            logic [31:0] ed;
            model(vecs[i].we, vecs[i].f3, int'(vecs[i].addr), vecs[i].data, ee, ed);
            issue_a(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].data, vecs[i].err, vecs[i].dout);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("a_data_held", data_a, 32'h55AA33CC);

        // Randomized traffic against the model over a small region.
        for (int w = 0; w < 16; w++) issue_a_model(1'b1, 3'b010, AW'(w * 4), $urandom);
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;          // idle cycle
            end else begin
                if ($urandom_range(0, 15) == 0) a = AW'(32'h1000 + $urandom_range(0, 63));
                else                            a = AW'($urandom_range(0, 63));
                issue_a_model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);

        // Wait-state instance: timing, read-back, and reset mid-request.
        issue_b_timed(1'b1, 3'b010, 14'h0020, 32'h11111111, 1'b0, 32'h0);
        issue_b_timed(1'b0, 3'b010, 14'h0020, 32'h0,        1'b0, 32'h11111111);
        issue_b_timed(1'b0, 3'b010, 14'h0022, 32'h0,        1'b1, 32'h0);

        we_s = 1; f3_s = 3'b010; addr_s = 14'h0020; data_s = 32'h22222222; req_b = 1;
        @(posedge clk); #1;                  // accepted on this edge
        req_b = 0;
        @(posedge clk); #1;
        rst_b = 1;
        @(negedge clk);
        chk("b_ready_during_reset", {31'd0, ready_b}, 32'd0);
        @(posedge clk); #1;
        rst_b = 0;
        @(negedge clk);
        chk("b_ready_after_midreset", {31'd0, ready_b}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("b_no_valid_after_drop", {31'd0, valid_b}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        issue_b_timed(1'b0, 3'b010, 14'h0020, 32'h0, 1'b0, 32'h11111111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
